// File: rtl/mem_arbiter.sv
// Two-requester (instruction fetch / data) arbiter for a single shared memory port.
// Round-robin grant, per-access timeout, and registered completion pulses.
module mem_arbiter #(
  parameter int unsigned TIMEOUT_CYCLES = 255
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        i_req,
  input  logic [31:0] i_addr,
  output logic [31:0] i_rdata,
  output logic        i_done,
  output logic        i_err,
  input  logic        d_req,
  input  logic        d_we,
  input  logic [3:0]  d_be,
  input  logic [31:0] d_addr,
  input  logic [31:0] d_wdata,
  output logic [31:0] d_rdata,
  output logic        d_done,
  output logic        d_err,
  output logic        mem_req,
  output logic        mem_we,
  output logic [3:0]  mem_be,
  output logic [31:0] mem_addr,
  output logic [31:0] mem_wdata,
  input  logic [31:0] mem_rdata,
  input  logic        mem_ack,
  output logic        busy
);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    I_ACC = 2'd1,
    D_ACC = 2'd2
  } state_t;

  localparam logic [15:0] LIMIT = 16'(TIMEOUT_CYCLES - 1);

  state_t      state_r, state_nxt;
  logic        last_d_r;
  logic [15:0] cnt_r;
  logic        we_r;
  logic [3:0]  be_r;
  logic [31:0] addr_r, wdata_r;
  logic [31:0] i_rdata_r, d_rdata_r;
  logic        i_done_r, d_done_r, i_err_r, d_err_r;
  logic        i_elig_s, d_elig_s;
  logic        grant_i_s, grant_d_s, finish_s, abort_s;

  // Next-state logic: round-robin grant in IDLE, ack/timeout exit from ACC
  always_comb begin
    state_nxt = state_r;
    grant_i_s = 1'b0;
    grant_d_s = 1'b0;
    finish_s  = 1'b0;
    abort_s   = 1'b0;
    // a requester still holding its request during its done cycle must not be re-granted
    i_elig_s  = i_req & ~i_done_r;
    d_elig_s  = d_req & ~d_done_r;
    case (state_r)
      IDLE: begin
        if (i_elig_s && (!d_elig_s || last_d_r)) begin
          state_nxt = I_ACC;
          grant_i_s = 1'b1;
        end else if (d_elig_s) begin
          state_nxt = D_ACC;
          grant_d_s = 1'b1;
        end else begin
          state_nxt = IDLE;
        end
      end
      I_ACC, D_ACC: begin
        if (mem_ack) begin
          finish_s  = 1'b1;
          state_nxt = IDLE;
        end else if (cnt_r == LIMIT) begin
          abort_s   = 1'b1;
          state_nxt = IDLE;
        end else begin
          state_nxt = state_r;
        end
      end
      default: state_nxt = IDLE;
    endcase
  end

  // State register
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_r <= IDLE;
    end else begin
      state_r <= state_nxt;
    end
  end

  // Command latch, wait counter, completion pulses and read-data capture
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      last_d_r  <= 1'b1;
      cnt_r     <= 16'd0;
      we_r      <= 1'b0;
      be_r      <= 4'd0;
      addr_r    <= 32'd0;
      wdata_r   <= 32'd0;
      i_rdata_r <= 32'd0;
      d_rdata_r <= 32'd0;
      i_done_r  <= 1'b0;
      d_done_r  <= 1'b0;
      i_err_r   <= 1'b0;
      d_err_r   <= 1'b0;
    end else begin
      i_done_r <= 1'b0;
      d_done_r <= 1'b0;
      i_err_r  <= 1'b0;
      d_err_r  <= 1'b0;
      if (grant_i_s) begin
        cnt_r   <= 16'd0;
        we_r    <= 1'b0;
        be_r    <= 4'b1111;
        addr_r  <= i_addr;
        wdata_r <= 32'd0;
      end else if (grant_d_s) begin
        cnt_r   <= 16'd0;
        we_r    <= d_we;
        be_r    <= d_be;
        addr_r  <= d_addr;
        wdata_r <= d_wdata;
      end else if (finish_s || abort_s) begin
        // command registers return to zero so the port is quiet in IDLE
        cnt_r    <= 16'd0;
        we_r     <= 1'b0;
        be_r     <= 4'd0;
        addr_r   <= 32'd0;
        wdata_r  <= 32'd0;
        last_d_r <= (state_r == D_ACC);
        if (state_r == D_ACC) begin
          d_done_r <= 1'b1;
          d_err_r  <= abort_s;
          if (!we_r) begin
            d_rdata_r <= finish_s ? mem_rdata : 32'd0;
          end else begin
            d_rdata_r <= d_rdata_r;
          end
        end else begin
          i_done_r  <= 1'b1;
          i_err_r   <= abort_s;
          i_rdata_r <= finish_s ? mem_rdata : 32'd0;
        end
      end else if (state_r != IDLE) begin
        cnt_r <= cnt_r + 16'd1;
      end else begin
        cnt_r <= cnt_r;
      end
    end
  end

  assign mem_req   = (state_r != IDLE);
  assign busy      = (state_r != IDLE);
  assign mem_we    = we_r;
  assign mem_be    = be_r;
  assign mem_addr  = addr_r;
  assign mem_wdata = wdata_r;
  assign i_rdata   = i_rdata_r;
  assign d_rdata   = d_rdata_r;
  assign i_done    = i_done_r;
  assign d_done    = d_done_r;
  assign i_err     = i_err_r;
  assign d_err     = d_err_r;

endmodule

// File: tb/tb_mem_arbiter.sv
// Self-checking bench for mem_arbiter: directed scenarios plus randomized
// transactions checked against a transaction-level reference model.
module tb_mem_arbiter;
  localparam int TO = 4;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        i_req, d_req, d_we, mem_ack;
  logic [3:0]  d_be;
  logic [31:0] i_addr, d_addr, d_wdata, mem_rdata;
  logic [31:0] i_rdata, d_rdata, mem_addr, mem_wdata;
  logic        i_done, i_err, d_done, d_err, mem_req, mem_we, busy;
  logic [3:0]  mem_be;

  mem_arbiter #(.TIMEOUT_CYCLES(TO)) dut (
    .clk(clk), .rst_n(rst_n),
    .i_req(i_req), .i_addr(i_addr), .i_rdata(i_rdata), .i_done(i_done), .i_err(i_err),
    .d_req(d_req), .d_we(d_we), .d_be(d_be), .d_addr(d_addr), .d_wdata(d_wdata),
    .d_rdata(d_rdata), .d_done(d_done), .d_err(d_err),
    .mem_req(mem_req), .mem_we(mem_we), .mem_be(mem_be), .mem_addr(mem_addr),
    .mem_wdata(mem_wdata), .mem_rdata(mem_rdata), .mem_ack(mem_ack), .busy(busy)
  );

  always #5 clk = ~clk;

  int          total = 0;
  int          bad = 0;
  bit          exp_last_d;
  logic [31:0] exp_i_rdata, exp_d_rdata;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s got=%h exp=%h at %0t", tag, got, exp, $time);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic check_idle(input string tag);
    check({tag, "_mem_req"}, 32'(mem_req), 32'd0);
    check({tag, "_busy"}, 32'(busy), 32'd0);
    check({tag, "_mem_addr"}, mem_addr, 32'd0);
    check({tag, "_mem_be"}, 32'(mem_be), 32'd0);
    check({tag, "_i_done"}, 32'(i_done), 32'd0);
    check({tag, "_d_done"}, 32'(d_done), 32'd0);
  endtask

  // Called in the first access cycle; returns in the done cycle.
  // lat = number of wait cycles before ack; lat >= TO means the memory never answers.
  task automatic do_access(input bit is_d, input int lat, input logic [31:0] data);
    bit fin = 1'b0;
    bit acked = 1'b0;
    logic [31:0] rd;
    for (int k = 0; k < TO && !fin; k++) begin
      check("acc_mem_req", 32'(mem_req), 32'd1);
      check("acc_busy", 32'(busy), 32'd1);
      if (is_d) begin
        check("d_mem_addr", mem_addr, d_addr);
        check("d_mem_we", 32'(mem_we), 32'(d_we));
        check("d_mem_be", 32'(mem_be), 32'(d_be));
        check("d_mem_wdata", mem_wdata, d_wdata);
      end else begin
        check("i_mem_addr", mem_addr, i_addr);
        check("i_mem_we", 32'(mem_we), 32'd0);
        check("i_mem_be", 32'(mem_be), 32'hF);
      end
      if (k == lat) begin
        mem_ack   = 1'b1;
        mem_rdata = data;
      end
      step();
      mem_ack   = 1'b0;
      mem_rdata = $urandom;
      if (k == lat) begin
        fin   = 1'b1;
        acked = 1'b1;
      end else if (k == TO - 1) begin
        fin = 1'b1;
      end
    end
    rd = acked ? data : 32'd0;
    if (is_d) begin
      check("d_done", 32'(d_done), 32'd1);
      check("d_err", 32'(d_err), 32'(!acked));
      check("d_i_done", 32'(i_done), 32'd0);
      check("d_i_err", 32'(i_err), 32'd0);
      if (!d_we) exp_d_rdata = rd;
      check("d_rdata", d_rdata, exp_d_rdata);
      d_req = 1'b0;
    end else begin
      check("i_done", 32'(i_done), 32'd1);
      check("i_err", 32'(i_err), 32'(!acked));
      check("i_d_done", 32'(d_done), 32'd0);
      check("i_d_err", 32'(d_err), 32'd0);
      exp_i_rdata = rd;
      check("i_rdata", i_rdata, exp_i_rdata);
      i_req = 1'b0;
    end
    check("done_busy", 32'(busy), 32'd0);
    check("done_mem_req", 32'(mem_req), 32'd0);
    exp_last_d = is_d;
  endtask

  task automatic transact(input bit want_i, input bit want_d, input int lat_i, input int lat_d,
                          input logic [31:0] di, input logic [31:0] dd);
    i_req = want_i;
    d_req = want_d;
    step();
    if (want_i && want_d) begin
      if (exp_last_d) begin
        do_access(1'b0, lat_i, di);
        step();
        do_access(1'b1, lat_d, dd);
      end else begin
        do_access(1'b1, lat_d, dd);
        step();
        do_access(1'b0, lat_i, di);
      end
    end else if (want_i) begin
      do_access(1'b0, lat_i, di);
    end else if (want_d) begin
      do_access(1'b1, lat_d, dd);
    end
    step();
    check_idle("post");
  endtask

  initial begin
    rst_n = 1'b0; i_req = 1'b0; d_req = 1'b0; d_we = 1'b0; mem_ack = 1'b0;
    d_be = 4'd0; i_addr = 32'd0; d_addr = 32'd0; d_wdata = 32'd0; mem_rdata = 32'd0;
    exp_last_d = 1'b1; exp_i_rdata = 32'd0; exp_d_rdata = 32'd0;
    step();
    step();
    check_idle("rst");
    check("rst_mem_we", 32'(mem_we), 32'd0);
    check("rst_mem_wdata", mem_wdata, 32'd0);
    check("rst_i_err", 32'(i_err), 32'd0);
    check("rst_d_err", 32'(d_err), 32'd0);
    check("rst_i_rdata", i_rdata, 32'd0);
    check("rst_d_rdata", d_rdata, 32'd0);
    rst_n = 1'b1;
    step();

    // contention straight after reset, then again
    i_addr = 32'h0000_0040; d_addr = 32'h0000_3000; d_we = 1'b0; d_be = 4'hF;
    transact(1'b1, 1'b1, 0, 1, 32'h1111_1111, 32'h2222_2222);
    transact(1'b1, 1'b1, 2, 0, 32'h3333_3333, 32'h4444_4444);

    // single fetch at minimum latency
    i_addr = 32'h0000_0100;
    transact(1'b1, 1'b0, 0, 0, 32'h0050_0093, 32'd0);

    // store acked after 3 wait cycles (coincides with the timeout threshold)
    d_we = 1'b1; d_be = 4'b0011; d_addr = 32'h0000_2000; d_wdata = 32'hDEAD_BEEF;
    transact(1'b0, 1'b1, 0, 3, 32'd0, 32'h5555_5555);

    // load that times out
    d_we = 1'b0;
    transact(1'b0, 1'b1, 0, 99, 32'd0, 32'h6666_6666);

    // stray ack in IDLE has no effect
    mem_ack = 1'b1; mem_rdata = 32'hA5A5_A5A5;
    step();
    mem_ack = 1'b0;
    step();
    check_idle("stray");
    check("stray_i_rdata", i_rdata, exp_i_rdata);
    check("stray_d_rdata", d_rdata, exp_d_rdata);

    for (int n = 0; n < 40; n++) begin
      int mode;
      mode    = $urandom_range(1, 3);
      i_addr  = $urandom;
      d_addr  = $urandom;
      d_wdata = $urandom;
      d_we    = 1'($urandom_range(0, 1));
      d_be    = 4'($urandom_range(0, 15));
      transact((mode & 1) != 0, (mode & 2) != 0, $urandom_range(0, 5), $urandom_range(0, 5),
               $urandom, $urandom);
    end

    // reset in the middle of a fetch
    i_addr = 32'h0000_0200;
    i_req  = 1'b1;
    step();
    check("mid_mem_req", 32'(mem_req), 32'd1);
    #2 rst_n = 1'b0;
    #1;
    check("mid_rst_mem_req", 32'(mem_req), 32'd0);
    check("mid_rst_busy", 32'(busy), 32'd0);
    i_req = 1'b0;
    exp_last_d = 1'b1; exp_i_rdata = 32'd0; exp_d_rdata = 32'd0;
    #3 rst_n = 1'b1;
    for (int k = 0; k < 3; k++) begin
      step();
      check("post_rst_i_done", 32'(i_done), 32'd0);
      check("post_rst_busy", 32'(busy), 32'd0);
    end
    transact(1'b1, 1'b0, 1, 0, 32'h0BAD_F00D, 32'd0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/mem_arbiter.md
MEM_ARBITER -- requirements
Module: mem_arbiter

Interface
REQ-001 Parameter: TIMEOUT_CYCLES, default 255, number of access-state cycles without mem_ack before an access aborts; legal range 1..65535.
REQ-002 clk  input  1  single system clock; all state updates on the rising edge.
REQ-003 rst_n  input  1  reset, asynchronous assert, active-low.
REQ-004 i_req  input  1  instruction-fetch request, level, held until i_done.
REQ-005 i_addr  input  32  fetch address, stable while i_req is high.
REQ-006 i_rdata  output  32  fetched word, registered, valid while i_done is high.
REQ-007 i_done  output  1  one-cycle completion pulse for the fetch requester.
REQ-008 i_err  output  1  one-cycle timeout flag, coincident with i_done.
REQ-009 d_req  input  1  data request, level, held until d_done.
REQ-010 d_we  input  1  data write enable; 1 = store, 0 = load.
REQ-011 d_be  input  4  data byte enables.
REQ-012 d_addr  input  32  data address.
REQ-013 d_wdata  input  32  store data.
REQ-014 d_rdata  output  32  load data, registered.
REQ-015 d_done  output  1  one-cycle completion pulse for the data requester.
REQ-016 d_err  output  1  one-cycle timeout flag, coincident with d_done.
REQ-017 mem_req  output  1  shared memory-port request.
REQ-018 mem_we, mem_be, mem_addr, mem_wdata  output  1/4/32/32  shared memory-port command.
REQ-019 mem_rdata  input  32  memory read data, valid with mem_ack.
REQ-020 mem_ack  input  1  memory completion, one cycle.
REQ-021 busy  output  1  high whenever the state is not IDLE.

Function
REQ-022 FSM states SHALL be IDLE, I_ACC and D_ACC.
REQ-023 In IDLE with only one eligible request pending, the FSM SHALL go to that requester's ACC state on the next edge.
REQ-024 In IDLE with both requests eligible, the FSM SHALL grant the requester not recorded in last_grant (round-robin).
REQ-025 A requester whose done output is high in the current cycle SHALL be ineligible in that cycle, so a held request is never re-granted.
REQ-026 At grant, the command fields SHALL be latched into registers, and the mem_* outputs SHALL drive those registers during ACC.
  - I_ACC drives mem_we=0 and mem_be=4'b1111.
  - In IDLE, mem_req=0 and all mem_* command outputs are 0.
REQ-027 In ACC, mem_req SHALL be 1; mem_ack sampled high SHALL move the FSM to IDLE, with done=1 in the following cycle.
  - Minimum latency: request at cycle N, mem_req at N+1, done at N+2 when mem_ack arrives at N+1.
REQ-028 On a read ack, mem_rdata SHALL be captured into i_rdata or d_rdata; d_rdata SHALL be unchanged on store acks.
REQ-029 last_grant SHALL update to the served requester when its access completes or aborts.
REQ-030 A 16-bit wait counter SHALL clear at grant and increment on each ACC cycle without mem_ack.
  - When the counter equals TIMEOUT_CYCLES-1 and mem_ack is low, the access SHALL abort: FSM to IDLE, done=1 and err=1 next cycle, rdata for a read set to 0.
REQ-031 mem_ack while in IDLE SHALL be ignored, with no state or output change.
REQ-032 mem_ack and the timeout threshold in the same cycle SHALL be treated as a normal completion (err=0).
REQ-033 done and err outputs SHALL be high for exactly one cycle per granted access, and never simultaneously for both requesters.

Reset
REQ-034 While rst_n=0, the following SHALL hold and persist until the first edge after release:
  - state=IDLE, last_grant=D, counter=0;
  - mem_req=0 and all mem_* command outputs 0;
  - i_done, d_done, i_err, d_err = 0;
  - i_rdata = d_rdata = 0; busy=0.
REQ-035 Reset asserted mid-access SHALL abort the access immediately, with no done pulse after release.

Verification
REQ-036 Single fetch: i_req=1, i_addr=0x100, mem_ack at the first mem_req cycle with mem_rdata=0x00500093 -> mem_addr=0x100, mem_we=0, i_done one cycle later with i_rdata=0x00500093, done 2 cycles after the request.
REQ-037 Store: d_req=1, d_we=1, d_be=4'b0011, d_addr=0x2000, d_wdata=0xDEADBEEF, ack after 3 wait cycles -> mem_* fields match, d_done pulses once, d_rdata unchanged.
REQ-038 Contention after reset: i_req and d_req asserted in the same cycle -> I served first (last_grant=D), then D; repeat contention -> I first again.
REQ-039 Timeout: TIMEOUT_CYCLES=4, d_req load with no ack -> mem_req high for 4 cycles, then d_done=1 and d_err=1, d_rdata=0, busy=0.
REQ-040 Reset mid-access: rst_n low during I_ACC -> mem_req=0 and busy=0 asynchronously, no i_done after release, next i_req served normally.
